accum_bank: RTL and testbench

Parametrised, multi-bank successor to the column-skewed accumulator buffer. It sits after the systolic array. Each column's partial sums arrive one cycle later than the previous column's. The block stores them per row address, either overwriting or accumulating, using an internal skew pipeline. Write and read banks are separate, so one bank fills while the other drains to the output/activation stage.

---
 rtl/accum_bank_if.sv | 39 +++
 rtl/accum_bank.sv | 172 +++++++++++++++++
 tb/tb_accum_bank.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_bank_if.sv
// accum_bank_if: write-request, swap-control and read-port bundle for accum_bank.
// The master drives requests; the slave (the buffer) returns status and read data.
interface accum_bank_if #(
    parameter int unsigned SYS_COL    = 4,
    parameter int unsigned ACCUM_ROW  = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_BANK   = 2
);
    localparam int unsigned ADDR_WIDTH = $clog2(ACCUM_ROW);
    localparam int unsigned BANK_WIDTH = $clog2(NUM_BANK);

    logic                         wr_en_in;
    logic [ADDR_WIDTH-1:0]        wr_addr_in;
    logic                         wr_acc_in;
    logic signed [DATA_WIDTH-1:0] wr_data [SYS_COL];
    logic                         flush;
    logic                         swap_req;
    logic                         swap_ack;
    logic [BANK_WIDTH-1:0]        wr_bank;
    logic                         busy;
    logic                         rd_en;
    logic [BANK_WIDTH-1:0]        rd_bank;
    logic [ADDR_WIDTH-1:0]        rd_addr;
    logic signed [DATA_WIDTH-1:0] rd_data [SYS_COL];
    logic                         rd_valid;
    logic                         ovf;

    modport master (
        output wr_en_in, wr_addr_in, wr_acc_in, wr_data, flush, swap_req,
        output rd_en, rd_bank, rd_addr,
        input  swap_ack, wr_bank, busy, rd_data, rd_valid, ovf
    );

    modport slave (
        input  wr_en_in, wr_addr_in, wr_acc_in, wr_data, flush, swap_req,
        input  rd_en, rd_bank, rd_addr,
        output swap_ack, wr_bank, busy, rd_data, rd_valid, ovf
    );
endinterface

// File: rtl/accum_bank.sv
// accum_bank: multi-bank, column-skewed accumulator buffer fed by the systolic array.
// Optional feature macro ACCUM_SAT_EN: saturating accumulate with a sticky ovf flag.
module accum_bank #(
    parameter int unsigned SYS_COL    = 4,
    parameter int unsigned ACCUM_ROW  = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_BANK   = 2
) (
    input logic          clk,
    input logic          rst,
    accum_bank_if.slave  bus
);
    localparam int unsigned ADDR_WIDTH = $clog2(ACCUM_ROW);
    localparam int unsigned BANK_WIDTH = $clog2(NUM_BANK);
    localparam int unsigned PIPE_N     = (SYS_COL > 1) ? SYS_COL - 1 : 1;
`ifdef ACCUM_SAT_EN
    localparam int unsigned SUM_W      = DATA_WIDTH + 1;
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`else
    localparam int unsigned SUM_W      = DATA_WIDTH;
`endif
    // Extra MSB keeps the range compare meaningful for power-of-two sizes too.
    localparam logic [ADDR_WIDTH:0] ROW_LIM  = (ADDR_WIDTH+1)'(ACCUM_ROW);
    localparam logic [BANK_WIDTH:0] BANK_LIM = (BANK_WIDTH+1)'(NUM_BANK);

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  acc;
        logic [BANK_WIDTH-1:0] bank;
    } stage_t;

    logic signed [DATA_WIDTH-1:0] mem [NUM_BANK][ACCUM_ROW][SYS_COL];
    stage_t                       pipe   [PIPE_N];   // pipe[k] drives column k+1
    stage_t                       pipe_d [PIPE_N];
    stage_t                       stg_c  [SYS_COL];  // request owning each column this cycle
    logic signed [SUM_W-1:0]      sum_c  [SYS_COL];
    logic signed [DATA_WIDTH-1:0] wval_c [SYS_COL];
    logic [SYS_COL-1:0]           wen_c;
    logic                         addr_ok_c;
    logic                         rd_ok_c;
    logic                         swap_ok_c;
    logic                         busy_d;

    assign addr_ok_c = {1'b0, bus.wr_addr_in} < ROW_LIM;
    assign rd_ok_c   = ({1'b0, bus.rd_bank} < BANK_LIM) && ({1'b0, bus.rd_addr} < ROW_LIM);
    assign swap_ok_c = bus.swap_req && !bus.busy && !bus.wr_en_in;

    // Column view of the skew pipeline plus next pipeline state.
    always_comb begin
        stg_c[0].valid = bus.wr_en_in && !bus.flush && addr_ok_c;
        stg_c[0].addr  = bus.wr_addr_in;
        stg_c[0].acc   = bus.wr_acc_in;
        stg_c[0].bank  = bus.wr_bank;
        for (int unsigned k = 1; k < SYS_COL; k++) begin
            stg_c[k] = pipe[k-1];
        end
        for (int unsigned k = 0; k < PIPE_N; k++) begin
            pipe_d[k] = '0;
        end
        if (!bus.flush && SYS_COL > 1) begin
            pipe_d[0] = stg_c[0];
            for (int unsigned k = 1; k < PIPE_N; k++) begin
                pipe_d[k] = pipe[k-1];
            end
        end
        busy_d = 1'b0;
        for (int unsigned k = 0; k < PIPE_N; k++) begin
            busy_d = busy_d | pipe_d[k].valid;
        end
    end

    // Per-column read-modify-write value; the live memory word makes same-row chains correct.
    always_comb begin
        for (int unsigned j = 0; j < SYS_COL; j++) begin
            wen_c[j]  = stg_c[j].valid && !bus.flush;
            sum_c[j]  = SUM_W'(mem[stg_c[j].bank][stg_c[j].addr][j]) + SUM_W'(bus.wr_data[j]);
            wval_c[j] = bus.wr_data[j];
            if (stg_c[j].acc) begin
`ifdef ACCUM_SAT_EN
                if (sum_c[j][DATA_WIDTH] != sum_c[j][DATA_WIDTH-1]) begin
                    wval_c[j] = sum_c[j][DATA_WIDTH] ? SAT_MIN : SAT_MAX;
                end else begin
                    wval_c[j] = sum_c[j][DATA_WIDTH-1:0];
                end
`else
                wval_c[j] = sum_c[j][DATA_WIDTH-1:0];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned b = 0; b < NUM_BANK; b++) begin
                for (int unsigned a = 0; a < ACCUM_ROW; a++) begin
                    for (int unsigned j = 0; j < SYS_COL; j++) begin
                        mem[b][a][j] <= '0;
                    end
                end
            end
        end else begin
            for (int unsigned j = 0; j < SYS_COL; j++) begin
                if (wen_c[j]) begin
                    mem[stg_c[j].bank][stg_c[j].addr][j] <= wval_c[j];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < PIPE_N; k++) begin
                pipe[k] <= '0;
            end
            bus.busy     <= 1'b0;
            bus.swap_ack <= 1'b0;
            bus.wr_bank  <= '0;
        end else begin
            pipe         <= pipe_d;
            bus.busy     <= busy_d;
            bus.swap_ack <= swap_ok_c;
            if (swap_ok_c) begin
                bus.wr_bank <= (bus.wr_bank == BANK_WIDTH'(NUM_BANK - 1)) ? '0
                               : bus.wr_bank + BANK_WIDTH'(1);
            end
        end
    end

    // Read port returns pre-edge contents, so a same-cycle commit is not visible yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_valid <= 1'b0;
            for (int unsigned j = 0; j < SYS_COL; j++) begin
                bus.rd_data[j] <= '0;
            end
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                for (int unsigned j = 0; j < SYS_COL; j++) begin
                    bus.rd_data[j] <= rd_ok_c ? mem[bus.rd_bank][bus.rd_addr][j] : '0;
                end
            end
        end
    end

`ifdef ACCUM_SAT_EN
    logic [SYS_COL-1:0] clamp_c;

    always_comb begin
        for (int unsigned j = 0; j < SYS_COL; j++) begin
            clamp_c[j] = wen_c[j] && stg_c[j].acc
                         && (sum_c[j][DATA_WIDTH] != sum_c[j][DATA_WIDTH-1]);
        end
    end

    // Sticky until reset or an accepted swap (no commit can coincide with a swap).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ovf <= 1'b0;
        end else if (swap_ok_c) begin
            bus.ovf <= 1'b0;
        end else if (|clamp_c) begin
            bus.ovf <= 1'b1;
        end
    end
`else
    assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_accum_bank.sv
// tb_accum_bank: randomized and directed bench for accum_bank against a per-row,
// per-column reference memory with a queue of in-flight skewed requests.
module tb_accum_bank;
    localparam int unsigned SC = 4;
    localparam int unsigned AR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned NB = 2;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b1;

    accum_bank_if #(.SYS_COL(SC), .ACCUM_ROW(AR), .DATA_WIDTH(DW), .NUM_BANK(NB)) bus ();
    accum_bank #(.SYS_COL(SC), .ACCUM_ROW(AR), .DATA_WIDTH(DW), .NUM_BANK(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]                 addr;
        logic                       acc;
        logic                       bank;
        logic [2:0]                 next;
        logic [SC-1:0][DW-1:0]      data;
    } req_t;

    req_t                 q [$];
    logic signed [DW-1:0] mm [NB][AR][SC];
    logic signed [DW-1:0] exp_rd [SC];
    logic                 exp_rd_valid, exp_busy, exp_swap_ack, exp_ovf;
    int                   exp_wr_bank;
    int                   n_checks = 0;
    int                   n_fail = 0;
    logic                 chk_en = 1'b0;

    logic                 n_wr_en, n_acc, n_flush, n_swap, n_rd_en, n_rd_bank;
    logic [1:0]           n_addr, n_rd_addr;
    logic signed [DW-1:0] n_row [SC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Every cycle: outputs after the edge versus the model's post-edge view.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("rd_valid", 32'(bus.rd_valid), 32'(exp_rd_valid));
            chk("busy", 32'(bus.busy), 32'(exp_busy));
            chk("swap_ack", 32'(bus.swap_ack), 32'(exp_swap_ack));
            chk("wr_bank", 32'(bus.wr_bank), 32'(exp_wr_bank));
            chk("ovf", 32'(bus.ovf), 32'(exp_ovf));
            for (int j = 0; j < SC; j++) begin
                chk($sformatf("rd_data[%0d]", j), bus.rd_data[j], exp_rd[j]);
            end
        end
    end

    function automatic void apply(int b, int a, int j, logic acc, logic signed [DW-1:0] d);
        longint s;
        if (!acc) begin
            mm[b][a][j] = d;
            return;
        end
        s = longint'(mm[b][a][j]) + longint'(d);
`ifdef ACCUM_SAT_EN
        if (s > SMAX) begin
            s = SMAX;
            exp_ovf = 1'b1;
        end else if (s < SMIN) begin
            s = SMIN;
            exp_ovf = 1'b1;
        end
`endif
        mm[b][a][j] = s[DW-1:0];
    endfunction

    task automatic idle();
        n_wr_en = 0; n_acc = 0; n_flush = 0; n_swap = 0; n_rd_en = 0;
        n_rd_bank = 0; n_addr = 0; n_rd_addr = 0;
        for (int j = 0; j < SC; j++) n_row[j] = '0;
    endtask

    // One clock: drive the staged inputs, advance the model across the edge, return at negedge.
    task automatic step();
        logic busy_pre, accept;
        req_t r;
        bus.wr_en_in = n_wr_en; bus.wr_addr_in = n_addr; bus.wr_acc_in = n_acc;
        bus.flush = n_flush; bus.swap_req = n_swap;
        bus.rd_en = n_rd_en; bus.rd_bank = n_rd_bank; bus.rd_addr = n_rd_addr;
        for (int j = 0; j < SC; j++) bus.wr_data[j] = DW'($urandom());
        if (n_wr_en) bus.wr_data[0] = n_row[0];
        foreach (q[i]) bus.wr_data[q[i].next] = q[i].data[q[i].next];

        busy_pre     = (q.size() != 0);
        accept       = n_swap && !busy_pre && !n_wr_en;
        exp_rd_valid = n_rd_en;
        if (n_rd_en) for (int j = 0; j < SC; j++) exp_rd[j] = mm[n_rd_bank][n_rd_addr][j];
        exp_swap_ack = accept;
        if (n_flush) begin
            q.delete();
        end else begin
            if (n_wr_en) begin
                r.addr = n_addr; r.acc = n_acc; r.bank = exp_wr_bank[0]; r.next = 3'd0;
                for (int j = 0; j < SC; j++) r.data[j] = n_row[j];
                q.push_back(r);
            end
            foreach (q[i]) begin
                apply(int'(q[i].bank), int'(q[i].addr), int'(q[i].next), q[i].acc,
                      q[i].data[q[i].next]);
                q[i].next = q[i].next + 3'd1;
            end
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (int'(q[i].next) == SC) q.delete(i);
            end
        end
        if (accept) begin
            exp_wr_bank = (exp_wr_bank + 1) % NB;
            exp_ovf = 1'b0;
        end
        exp_busy = (q.size() != 0);
        idle();
        @(negedge clk);
    endtask

    task automatic req(input logic [1:0] a, input logic acc,
                       input logic [31:0] d0, d1, d2, d3);
        n_wr_en = 1; n_addr = a; n_acc = acc;
        n_row[0] = d0; n_row[1] = d1; n_row[2] = d2; n_row[3] = d3;
        step();
    endtask

    task automatic drain();
        repeat (SC) step();
    endtask

    task automatic lit_row(input string name, input logic b, input logic [1:0] a,
                           input logic [31:0] v0, v1, v2, v3);
        logic [31:0] v [SC];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        n_rd_en = 1; n_rd_bank = b; n_rd_addr = a;
        step();
        for (int j = 0; j < SC; j++) chk($sformatf("%s[%0d]", name, j), bus.rd_data[j], v[j]);
    endtask

    task automatic model_reset();
        q.delete();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < AR; a++)
                for (int j = 0; j < SC; j++) mm[b][a][j] = '0;
        for (int j = 0; j < SC; j++) exp_rd[j] = '0;
        exp_rd_valid = 0; exp_busy = 0; exp_swap_ack = 0; exp_ovf = 0; exp_wr_bank = 0;
        bus.wr_en_in = 0; bus.wr_addr_in = 0; bus.wr_acc_in = 0; bus.flush = 0;
        bus.swap_req = 0; bus.rd_en = 0; bus.rd_bank = 0; bus.rd_addr = 0;
        for (int j = 0; j < SC; j++) bus.wr_data[j] = '0;
        idle();
    endtask

    logic [31:0] sat_val;
    logic        sat_ovf;
    logic [31:0] rnd;

    initial begin
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_wr_bank", 32'(bus.wr_bank), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        lit_row("rst_read", 1'b0, 2'd2, 0, 0, 0, 0);

        // Overwrite fill of bank 0, busy tail, then readback.
        for (int i = 0; i < 4; i++) req(2'(i), 1'b0, 4*i+1, 4*i+2, 4*i+3, 4*i+4);
        step(); step();
        chk("busy_tail_high", 32'(bus.busy), 32'd1);
        step();
        chk("busy_tail_low", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 4; i++) lit_row("fill", 1'b0, 2'(i), 4*i+1, 4*i+2, 4*i+3, 4*i+4);

        // Accumulate the same stream: every entry doubles.
        for (int i = 0; i < 4; i++) req(2'(i), 1'b1, 4*i+1, 4*i+2, 4*i+3, 4*i+4);
        drain();
        lit_row("acc_row3", 1'b0, 2'd3, 26, 28, 30, 32);

        // Back-to-back same-address chain.
        req(2'd0, 1'b0, 0, 0, 0, 0);
        repeat (3) req(2'd0, 1'b1, 1, 1, 1, 1);
        drain();
        lit_row("rmw_chain", 1'b0, 2'd0, 3, 3, 3, 3);

        // Swap refused while busy, accepted once drained.
        req(2'd3, 1'b1, 0, 0, 0, 0);
        n_swap = 1; step();
        chk("swap_busy_ack", 32'(bus.swap_ack), 32'd0);
        chk("swap_busy_bank", 32'(bus.wr_bank), 32'd0);
        drain();
        n_swap = 1; step();
        chk("swap_ack", 32'(bus.swap_ack), 32'd1);
        chk("swap_bank", 32'(bus.wr_bank), 32'd1);
        step();
        chk("swap_ack_pulse", 32'(bus.swap_ack), 32'd0);
        for (int i = 0; i < 4; i++) begin
            n_rd_en = 1; n_rd_bank = 0; n_rd_addr = 2'(i);
            req(2'(i), 1'b0, 7, 7, 7, 7);
        end
        drain();
        for (int i = 0; i < 4; i++) lit_row("bank1_sevens", 1'b1, 2'(i), 7, 7, 7, 7);
        lit_row("bank0_kept", 1'b0, 2'd0, 3, 3, 3, 3);
        n_swap = 1; step();
        chk("swap_wrap", 32'(bus.wr_bank), 32'd0);

        // Flush one cycle after the request: only column 0 lands.
        req(2'd1, 1'b0, 100, 101, 102, 103);
        n_flush = 1; step();
        drain();
        lit_row("flush_row1", 1'b0, 2'd1, 100, 12, 14, 16);

        // Read/write collision on row 2.
        req(2'd2, 1'b0, 9, 9, 9, 9);
        drain();
        n_rd_en = 1; n_rd_bank = 0; n_rd_addr = 2'd2;
        req(2'd2, 1'b0, 5, 5, 5, 5);
        chk("collide_old", bus.rd_data[0], 32'd9);
        n_rd_en = 1; n_rd_bank = 0; n_rd_addr = 2'd2;
        step();
        chk("collide_new", bus.rd_data[0], 32'd5);
        drain();

        // Positive overflow on accumulate.
`ifdef ACCUM_SAT_EN
        sat_val = 32'h7FFF_FFFF; sat_ovf = 1'b1;
`else
        sat_val = 32'h8000_0010; sat_ovf = 1'b0;
`endif
        req(2'd3, 1'b0, 32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h7FFF_FFF0);
        req(2'd3, 1'b1, 32'h20, 32'h20, 32'h20, 32'h20);
        drain();
        lit_row("sat_row3", 1'b0, 2'd3, sat_val, sat_val, sat_val, sat_val);
        chk("sat_ovf", 32'(bus.ovf), 32'(sat_ovf));
        n_swap = 1; step();
        chk("ovf_clear_on_swap", 32'(bus.ovf), 32'd0);

        // Randomized traffic including extremes, flushes, swaps and reads.
        for (int c = 0; c < 800; c++) begin
            n_wr_en = ($urandom_range(0, 3) != 0);
            n_addr = 2'($urandom_range(0, 3));
            n_acc = 1'($urandom_range(0, 1));
            for (int j = 0; j < SC; j++) begin
                rnd = $urandom();
                case ($urandom_range(0, 3))
                    0: n_row[j] = 32'h7FFF_FF00 + {24'd0, rnd[7:0]};
                    1: n_row[j] = 32'h8000_0000 + {24'd0, rnd[7:0]};
                    default: n_row[j] = 32'($urandom_range(0, 2000)) - 32'd1000;
                endcase
            end
            n_flush = ($urandom_range(0, 15) == 0);
            n_swap = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) n_wr_en = 0;
            n_rd_en = 1'($urandom_range(0, 1));
            n_rd_bank = 1'($urandom_range(0, 1));
            n_rd_addr = 2'($urandom_range(0, 3));
            step();
        end
        drain();

        // Reset in the middle of a row.
        req(2'd1, 1'b0, 11, 12, 13, 14);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("midrst_wr_bank", 32'(bus.wr_bank), 32'd0);
        chk("midrst_rd_data", bus.rd_data[0], 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < AR; a++) lit_row("post_rst", 1'(b), 2'(a), 0, 0, 0, 0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
